gate_sweep_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 23 ++
 rtl/gate_chk_hold_timer.sv | 30 +++
 rtl/gate_sweep_checker.sv | 118 +++++++++++
 tb/tb_gate_sweep_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate sweep checker.
// Truth tables are indexed by {a,b}: bit 0 holds the output for a=0,b=0.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

  // The counter only ever holds HOLD_CYCLES-1, so $clog2(HOLD_CYCLES) bits suffice.
  function automatic int hold_cnt_width(input int hold);
    int w;
    w = $clog2(hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gate_chk_hold_timer.sv
// Loadable down-counter that times the settle window of each driven vector.
// It stops at zero; load takes priority over counting.
module gate_chk_hold_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a/b through 00,01,10,11, samples y_in after each settle window and
// checks it against EXP_Y1/EXP_Y0. Define GATE_CHK_MISMATCH_LOG_EN for mismatch_mask.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] EXP_Y1      = TT_NAND,
  parameter logic [3:0] EXP_Y0      = TT_NOR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [1:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_idx
`ifdef GATE_CHK_MISMATCH_LOG_EN
  ,
  output logic [3:0] mismatch_mask
`endif
);

  localparam int            CW     = hold_cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  state_t     state, state_next;
  logic [1:0] idx;
  logic       accept, sample_pt, last_vec, mismatch;
  logic       timer_load, timer_zero;
  logic [2:0] err_inc;

  assign accept     = (state == IDLE) && start;
  assign sample_pt  = (state == DRIVE) && timer_zero;
  assign last_vec   = (idx == 2'd3);
  assign mismatch   = (y_in[1] != EXP_Y1[idx]) || (y_in[0] != EXP_Y0[idx]);
  assign err_inc    = err_count + {2'b00, mismatch};
  assign timer_load = accept || (sample_pt && !last_vec);

  gate_chk_hold_timer #(
    .WIDTH (CW)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (state == DRIVE),
    .load_val (RELOAD),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (sample_pt && last_vec) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == DRIVE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      err_count <= 3'd0;
      fail_idx  <= 2'd0;
      pass      <= 1'b0;
    end else if (accept) begin
      idx       <= 2'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      err_count <= 3'd0;
      fail_idx  <= 2'd0;
      pass      <= 1'b0;
    end else if (sample_pt) begin
      err_count <= err_inc;
      if (mismatch && (err_count == 3'd0)) fail_idx <= idx;
      if (!last_vec) begin
        idx            <= idx + 2'd1;
        {a_out, b_out} <= idx + 2'd1;
      end else begin
        // Last sample folds straight into pass so it is valid alongside done.
        {a_out, b_out} <= 2'b00;
        pass           <= (err_inc == 3'd0);
      end
    end
  end

`ifdef GATE_CHK_MISMATCH_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_mask <= 4'd0;
    end else if (accept) begin
      mismatch_mask <= 4'd0;
    end else if (sample_pt && mismatch) begin
      mismatch_mask[idx] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a table-driven gate model answers
// the DUT, expected sweep results are queued at start and checked by a monitor.
module tb_gate_sweep_checker;
  import gate_chk_pkg::*;

  localparam int         H  = 4;
  localparam logic [3:0] E1 = TT_NAND;
  localparam logic [3:0] E0 = TT_NOR;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_f = 1'b0;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_idx, y_in;
  logic       a_f, b_f, busy_f, done_f, pass_f;
  logic [2:0] err_f;
  logic [1:0] fail_f, y_f;
  logic [3:0] tab1 = E1, tab0 = E0;
`ifdef GATE_CHK_MISMATCH_LOG_EN
  logic [3:0] mask, mask_f;
`endif

  always #5 clk = ~clk;

  // Gate under check: arbitrary truth tables for y[1]/y[0], indexed by {a,b}.
  assign y_in = {tab1[{a_out, b_out}], tab0[{a_out, b_out}]};
  assign y_f  = {E1[{a_f, b_f}], E0[{a_f, b_f}]};

  gate_sweep_checker #(.HOLD_CYCLES(H), .EXP_Y1(E1), .EXP_Y0(E0)) u_dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .a_out (a_out), .b_out (b_out), .y_in (y_in),
    .busy (busy), .done (done), .pass (pass),
    .err_count (err_count), .fail_idx (fail_idx)
`ifdef GATE_CHK_MISMATCH_LOG_EN
    , .mismatch_mask (mask)
`endif
  );

  gate_sweep_checker #(.HOLD_CYCLES(1), .EXP_Y1(E1), .EXP_Y0(E0)) u_fast (
    .clk (clk), .rst_n (rst_n), .start (start_f),
    .a_out (a_f), .b_out (b_f), .y_in (y_f),
    .busy (busy_f), .done (done_f), .pass (pass_f),
    .err_count (err_f), .fail_idx (fail_f)
`ifdef GATE_CHK_MISMATCH_LOG_EN
    , .mismatch_mask (mask_f)
`endif
  );

  typedef struct {
    int         k;
    logic       pass;
    logic [2:0] err;
    logic [1:0] fidx;
    logic [3:0] mask;
  } exp_t;

  exp_t       q[$];
  exp_t       head;
  int         checks = 0, errors = 0, cyc = 0;
  bit         aborting = 1'b0;
  logic       last_pass = 1'b0;
  logic [2:0] last_err = 3'd0;
  logic [1:0] last_fidx = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a vector fails if either output differs from its expected table.
  function automatic exp_t model(input logic [3:0] t1, input logic [3:0] t0);
    exp_t e;
    e.k = 0; e.err = 3'd0; e.fidx = 2'd0; e.mask = 4'd0;
    for (int v = 0; v < 4; v++) begin
      if (t1[v] !== E1[v] || t0[v] !== E0[v]) begin
        if (e.err == 3'd0) e.fidx = v[1:0];
        e.err++;
        e.mask[v] = 1'b1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  // Monitor: cycle cyc here means "after posedge number cyc".
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) begin
        head = q[0];
        if (cyc >= head.k && cyc < head.k + 4 * H) begin
          check("busy", busy, 1'b1);
          check("vector", {a_out, b_out}, (cyc - head.k) / H);
          check("done_early", done, 1'b0);
        end else if (cyc == head.k + 4 * H) begin
          check("done", done, 1'b1);
          check("busy_in_done", busy, 1'b0);
          check("ab_in_done", {a_out, b_out}, 2'b00);
          check("pass", pass, head.pass);
          check("err_count", err_count, head.err);
          check("fail_idx", fail_idx, head.fidx);
`ifdef GATE_CHK_MISMATCH_LOG_EN
          check("mismatch_mask", mask, head.mask);
`endif
          last_pass = head.pass;
          last_err  = head.err;
          last_fidx = head.fidx;
          void'(q.pop_front());
        end else if (cyc > head.k + 4 * H) begin
          check("done_latency", cyc, head.k + 4 * H);
          void'(q.pop_front());
        end
      end else if (!aborting) begin
        check("spurious_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("held_pass", pass, last_pass);
        check("held_err", err_count, last_err);
        check("held_fail_idx", fail_idx, last_fidx);
      end
    end
  end

  task automatic run_sweep(input logic [3:0] t1, input logic [3:0] t0, input int glitch);
    exp_t e;
    @(negedge clk);
    tab1 = t1;
    tab0 = t0;
    e = model(t1, t0);
    e.k = cyc + 1;
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (glitch == 1) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else if (glitch == 2) begin
      repeat (4 * H) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 8 * H + 8 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      check("sweep_timeout", q.size(), 0);
      q.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: no summary after 1 ms");
    $fatal(1);
  end

  initial begin
    int         k, mode, glitch;
    logic [3:0] t1, t0;

    #2;
    check("rst_ab", {a_out, b_out}, 2'b00);
    check("rst_flags", {busy, done, pass}, 3'b000);
    check("rst_err", err_count, 3'd0);
    check("rst_fail_idx", fail_idx, 2'd0);
    check("rst_fast", {a_f, b_f, busy_f, done_f, pass_f, err_f, fail_f}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(E1, E0, 0);          // correct NAND/NOR
    run_sweep(E1, 4'b0000, 0);     // y[0] stuck-at-0
    run_sweep(E0, E1, 0);          // outputs swapped
    run_sweep(E1, E0, 1);          // start re-pulsed during DRIVE
    run_sweep(E1 ^ 4'b1000, E0, 2); // start pulsed during DONE

    // Abort mid-sweep with a reset after vector 01 has already failed.
    aborting = 1'b1;
    @(negedge clk);
    tab1  = E1;
    tab0  = E0 ^ 4'b0010;
    start = 1'b1;
    k     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    check("pre_reset_err", err_count, 3'd1);
    check("pre_reset_fail_idx", fail_idx, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ab", {a_out, b_out}, 2'b00);
    check("async_rst_flags", {busy, done, pass}, 3'b000);
    check("async_rst_err", err_count, 3'd0);
    check("async_rst_fail_idx", fail_idx, 2'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_pass = 1'b0;
    last_err  = 3'd0;
    last_fidx = 2'd0;
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_abort", done, 1'b0);
    end
    aborting = 1'b0;
    run_sweep(E1, E0, 0);

    for (int n = 0; n < 20; n++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0:       begin t1 = E1;      t0 = E0;      end
        1:       begin t1 = E1;      t0 = 4'b0000; end
        2:       begin t1 = E0;      t0 = E1;      end
        3:       begin t1 = TT_AND;  t0 = TT_OR;   end
        default: begin t1 = 4'($urandom); t0 = 4'($urandom); end
      endcase
      glitch = $urandom_range(0, 2);
      run_sweep(t1, t0, glitch);
    end

    // HOLD_CYCLES=1: a new vector every cycle, done right after edge k+4.
    @(negedge clk);
    start_f = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start_f = 1'b0;
    for (int v = 0; v < 4; v++) begin
      check("fast_vector", {a_f, b_f}, v);
      check("fast_busy", busy_f, 1'b1);
      check("fast_done_early", done_f, 1'b0);
      @(negedge clk);
    end
    check("fast_done_cycle", cyc, k + 4);
    check("fast_done", done_f, 1'b1);
    check("fast_pass", pass_f, 1'b1);
    check("fast_err", err_f, 3'd0);
    check("fast_fail_idx", fail_f, 2'd0);
`ifdef GATE_CHK_MISMATCH_LOG_EN
    check("fast_mask", mask_f, 4'd0);
`endif
    @(negedge clk);
    check("fast_done_one_cycle", done_f, 1'b0);
    check("fast_pass_held", pass_f, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
